// File: rtl/uart_tx_driver_if.sv
// uart_tx_driver_if: CPU IO-bus view of the memory-mapped UART transmitter.
// The CPU side (master) drives strobes, chip select, address and write data;
// the transmitter (slave) returns the status word.
interface uart_tx_driver_if;
   logic        iDoIOWrite;
   logic        iDoIORead;
   logic        iUartTxCtrl;
   logic [1:0]  iUartTxAddress;
   logic [7:0]  iUartTxDataToWrite;
   logic [15:0] oUartTxStatus;

   modport master (
      output iDoIOWrite,
      output iDoIORead,
      output iUartTxCtrl,
      output iUartTxAddress,
      output iUartTxDataToWrite,
      input  oUartTxStatus
   );

   modport slave (
      input  iDoIOWrite,
      input  iDoIORead,
      input  iUartTxCtrl,
      input  iUartTxAddress,
      input  iUartTxDataToWrite,
      output oUartTxStatus
   );
endinterface

// File: rtl/uart_tx_driver.sv
// uart_tx_driver: memory-mapped UART transmitter (8N1, LSB first).
// Bytes written to DATA (addr 2'b00) enter a FIFO that the serializer drains
// autonomously; STATUS (addr 2'b10) reports busy/full/empty/overflow/count.
// Optional feature macro UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit.
module uart_tx_driver #(
   parameter int unsigned BAUD_DIV   = 200,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned FIFO_AW    = 3
) (
   input  logic            iCpuClock,
   input  logic            iCpuReset,
   uart_tx_driver_if.slave bus,
   output logic            oFpgaUartToPc
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
      ST_PARITY = 3'd4
   } state_t;

   // Even parity of the original (unshifted) frame byte.
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3
   } state_t;
`endif

   localparam logic [15:0]        BAUD_LAST = 16'(BAUD_DIV - 1);
   localparam logic [FIFO_AW:0]   FULL_CNT  = (FIFO_AW + 1)'(FIFO_DEPTH);
   localparam logic [FIFO_AW:0]   CNT_ZERO  = (FIFO_AW + 1)'(0);
   localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

   logic [7:0]         fifo_mem_q [FIFO_DEPTH];
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               ovf_q, ovf_d;
   state_t             state_q, state_d;
   logic [15:0]        baud_q, baud_d;
   logic [2:0]         bit_q, bit_d;
   logic [7:0]         shift_q, shift_d;
   logic               line_q, line_d;
`ifdef UART_TX_PARITY_EN
   logic               parity_q, parity_d;
`endif

   logic        push_s, rd_s, pop_s, accept_s, full_s, empty_s, busy_s, baud_end_s;
   logic [7:0]  head_s;
   logic [15:0] status_s;

   assign push_s     = bus.iUartTxCtrl & bus.iDoIOWrite & (bus.iUartTxAddress == 2'b00);
   assign rd_s       = bus.iUartTxCtrl & bus.iDoIORead  & (bus.iUartTxAddress == 2'b10);
   assign full_s     = (count_q == FULL_CNT);
   assign empty_s    = (count_q == CNT_ZERO);
   assign busy_s     = (state_q != ST_IDLE) | ~empty_s;
   assign baud_end_s = (baud_q == BAUD_LAST);
   assign head_s     = fifo_mem_q[rd_ptr_q];
   // A pop frees a slot on the same edge, so a push into a full FIFO that is
   // popping at that edge is accepted.
   assign accept_s   = push_s & (~full_s | pop_s);

   // Serializer next state: frame sequencing, baud timing and FIFO pop request.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      pop_s    = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         ST_IDLE: begin
            baud_d = 16'd0;
            if (!empty_s) begin
               pop_s    = 1'b1;
               bit_d    = 3'd0;
               shift_d  = head_s;
`ifdef UART_TX_PARITY_EN
               parity_d = even_parity(head_s);
`endif
               state_d  = ST_START;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_START: begin
            if (baud_end_s) begin
               baud_d  = 16'd0;
               state_d = ST_DATA;
            end else begin
               baud_d  = baud_q + 16'd1;
            end
         end
         ST_DATA: begin
            if (baud_end_s) begin
               baud_d  = 16'd0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               baud_d  = baud_q + 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (baud_end_s) begin
               baud_d  = 16'd0;
               state_d = ST_STOP;
            end else begin
               baud_d  = baud_q + 16'd1;
            end
         end
`endif
         ST_STOP: begin
            if (baud_end_s) begin
               baud_d = 16'd0;
               // Chain straight into the next frame when data is waiting.
               if (!empty_s) begin
                  pop_s    = 1'b1;
                  bit_d    = 3'd0;
                  shift_d  = head_s;
`ifdef UART_TX_PARITY_EN
                  parity_d = even_parity(head_s);
`endif
                  state_d  = ST_START;
               end else begin
                  state_d  = ST_IDLE;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            baud_d  = 16'd0;
         end
      endcase
   end

   // Line level for the current state; registered below so the pin never glitches.
   always_comb begin
      line_d = 1'b1;
      case (state_q)
         ST_START:  line_d = 1'b0;
         ST_DATA:   line_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: line_d = parity_q;
`endif
         default:   line_d = 1'b1;
      endcase
   end

   // FIFO pointer/count/overflow next state; an overflow set beats a read-clear.
   always_comb begin
      wr_ptr_d = accept_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({accept_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      if (push_s && !accept_s) begin
         ovf_d = 1'b1;
      end else if (rd_s) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Status word, only driven while selected-and-reading and out of reset.
   always_comb begin
      status_s = 16'h0000;
      if (iCpuReset && rd_s) begin
         status_s[0]             = busy_s;
         status_s[1]             = full_s;
         status_s[2]             = empty_s;
         status_s[3]             = ovf_q;
         status_s[4 +: FIFO_AW+1] = count_q;
      end else begin
         status_s = 16'h0000;
      end
   end

   assign bus.oUartTxStatus = status_s;
   assign oFpgaUartToPc     = line_q;

   // FIFO storage: data written only on accepted pushes, contents need no reset.
   always_ff @(posedge iCpuClock) begin
      if (accept_s) begin
         fifo_mem_q[wr_ptr_q] <= bus.iUartTxDataToWrite;
      end
   end

   // State registers; reset aborts any frame and forces the line high at once.
   always_ff @(posedge iCpuClock or negedge iCpuReset) begin
      if (!iCpuReset) begin
         state_q  <= ST_IDLE;
         baud_q   <= 16'd0;
         bit_q    <= 3'd0;
         shift_q  <= 8'd0;
         line_q   <= 1'b1;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         line_q   <= line_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule
